// File: rtl/cdp18xx_pkg.sv
// Shared CDP18xx constants: 1802 state codes and the responder's cycle-state enum.
// The core and the cdp1861 use the same state codes.
package cdp18xx_pkg;
  localparam logic [1:0] SC_FETCH = 2'd0;
  localparam logic [1:0] SC_EXEC  = 2'd1;
  localparam logic [1:0] SC_DMA   = 2'd2;
  localparam logic [1:0] SC_INT   = 2'd3;

  // Wide enough for up to 16 clocks per machine cycle
  localparam int PHASE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CPU,
    ST_DMA,
    ST_INT
  } cyc_state_e;
endpackage

// File: rtl/cdp1802_dma_responder_if.sv
// Bus between the DMA responder and its neighbours: core requests, cdp1861 DMA/INT, and RAM.
interface cdp1802_dma_responder_if;
  logic        dma_out_req;
  logic        int_req;
  logic        cpu_req;
  logic [1:0]  cpu_sc;
  logic        ie_set;
  logic        r0_load;
  logic [15:0] r0_din;
  logic [7:0]  mem_q;
  logic        tpa;
  logic        tpb;
  logic [1:0]  sc;
  logic        cpu_grant;
  logic        mem_rd;
  logic [15:0] mem_a;
  logic [7:0]  dma_data;
  logic        int_ack;
  logic        ie;
  logic [15:0] r0;

  modport slave (
    input  dma_out_req, int_req, cpu_req, cpu_sc, ie_set, r0_load, r0_din, mem_q,
    output tpa, tpb, sc, cpu_grant, mem_rd, mem_a, dma_data, int_ack, ie, r0
  );

  modport master (
    output dma_out_req, int_req, cpu_req, cpu_sc, ie_set, r0_load, r0_din, mem_q,
    input  tpa, tpb, sc, cpu_grant, mem_rd, mem_a, dma_data, int_ack, ie, r0
  );
endinterface

// File: rtl/cdp1802_dma_responder_cycle_timer.sv
// Free-running machine-cycle phase counter with TPA/TPB decode and a last-phase strobe.
module cdp1802_cycle_timer
  import cdp18xx_pkg::*;
#(
  parameter int CLKS_PER_CYCLE = 8,
  parameter int TPA_PHASE      = 1,
  parameter int TPB_PHASE      = 6
) (
  input  logic               i_clk,
  input  logic               i_reset,
  output logic [PHASE_W-1:0] o_phase,
  output logic               o_tpa,
  output logic               o_tpb,
  output logic               o_last
);
  logic [PHASE_W-1:0] r_phase;

  always_ff @(posedge i_clk) begin
    if (i_reset)     r_phase <= '0;
    else if (o_last) r_phase <= '0;
    else             r_phase <= r_phase + PHASE_W'(1);
  end

  assign o_phase = r_phase;
  assign o_last  = (r_phase == PHASE_W'(CLKS_PER_CYCLE - 1));
  assign o_tpa   = (r_phase == PHASE_W'(TPA_PHASE));
  assign o_tpb   = (r_phase == PHASE_W'(TPB_PHASE));
endmodule

// File: rtl/cdp1802_dma_responder.sv
// CPU-side responder to cdp1861 DMA-out and interrupt requests: cycle arbitration,
// R0 display pointer, IE flag, and the DMA byte fetch from RAM.
module cdp1802_dma_responder
  import cdp18xx_pkg::*;
#(
  parameter int CLKS_PER_CYCLE = 8,
  parameter int TPA_PHASE      = 1,
  parameter int TPB_PHASE      = 6
) (
  input logic                    i_clk,
  input logic                    i_reset,
  cdp1802_dma_responder_if.slave bus
);
  logic [PHASE_W-1:0] w_phase;
  logic               w_tpa, w_tpb, w_last;

  cyc_state_e  r_state, w_state_nxt;
  logic [1:0]  r_cpu_sc, w_cpu_sc_nxt;
  logic [15:0] r_r0;
  logic [7:0]  r_dma_data;
  logic        r_ie;
  logic        w_int_ack;

  cdp1802_cycle_timer #(
    .CLKS_PER_CYCLE (CLKS_PER_CYCLE),
    .TPA_PHASE      (TPA_PHASE),
    .TPB_PHASE      (TPB_PHASE)
  ) u_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .o_phase (w_phase),
    .o_tpa   (w_tpa),
    .o_tpb   (w_tpb),
    .o_last  (w_last)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_cpu_sc <= SC_EXEC;
    end else begin
      r_state  <= w_state_nxt;
      r_cpu_sc <= w_cpu_sc_nxt;
    end
  end

  // Requests are only looked at on the last phase; short pulses in between are dropped.
  always_comb begin
    w_state_nxt  = r_state;
    w_cpu_sc_nxt = r_cpu_sc;
    if (w_last) begin
      if (bus.dma_out_req)            w_state_nxt = ST_DMA;
      else if (bus.int_req && r_ie)   w_state_nxt = ST_INT;
      else if (bus.cpu_req) begin
        w_state_nxt  = ST_CPU;
        w_cpu_sc_nxt = bus.cpu_sc;
      end else                        w_state_nxt = ST_IDLE;
    end

    bus.sc        = SC_EXEC;
    bus.cpu_grant = 1'b0;
    bus.mem_rd    = 1'b0;
    bus.mem_a     = 16'h0000;
    w_int_ack     = 1'b0;
    case (r_state)
      ST_CPU: begin
        bus.sc        = r_cpu_sc;
        bus.cpu_grant = 1'b1;
      end
      ST_DMA: begin
        bus.sc     = SC_DMA;
        bus.mem_a  = r_r0;
        bus.mem_rd = (w_phase == PHASE_W'(2));
      end
      ST_INT: begin
        bus.sc    = SC_INT;
        w_int_ack = w_tpb && !i_reset;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_r0       <= 16'h0000;
      r_dma_data <= 8'h00;
      r_ie       <= 1'b1;
    end else begin
      if (bus.r0_load)                      r_r0 <= bus.r0_din;
      else if (r_state == ST_DMA && w_last) r_r0 <= r_r0 + 16'd1;
      // RAM answers one clock after the phase-2 strobe
      if (r_state == ST_DMA && w_phase == PHASE_W'(3)) r_dma_data <= bus.mem_q;
      if (w_int_ack)       r_ie <= 1'b0;
      else if (bus.ie_set) r_ie <= 1'b1;
    end
  end

  assign bus.tpa      = w_tpa;
  assign bus.tpb      = w_tpb;
  assign bus.dma_data = r_dma_data;
  assign bus.int_ack  = w_int_ack;
  assign bus.ie       = r_ie;
  assign bus.r0       = r_r0;
endmodule

// File: tb/tb_cdp1802_dma_responder.sv
// Directed bench for cdp1802_dma_responder: idle timing, DMA bursts, INT/IE handling,
// R0 wrap and load priority, CPU cycles, and mid-cycle reset.
module tb_cdp1802_dma_responder;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   mphase;
  logic [7:0] ram [0:65535];

  cdp1802_dma_responder_if bus ();

  cdp1802_dma_responder #(
    .CLKS_PER_CYCLE (8),
    .TPA_PHASE      (1),
    .TPB_PHASE      (6)
  ) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Reference phase: independent count of clocks since reset, modulo 8
  always @(posedge clk) begin
    if (reset) mphase <= 0;
    else       mphase <= (mphase == 7) ? 0 : mphase + 1;
  end

  always @(posedge clk) if (bus.mem_rd) bus.mem_q <= ram[bus.mem_a];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mphase != p && n < 40);
    if (mphase != p) begin
      n_tests++;
      n_fail++;
      $error("FAIL wait_phase: observed %0d expected %0d", mphase, p);
    end
  endtask

  task automatic load_r0(input logic [15:0] v);
    bus.r0_load = 1'b1;
    bus.r0_din  = v;
    @(negedge clk);
    bus.r0_load = 1'b0;
  endtask

  initial begin
    bus.dma_out_req = 0; bus.int_req = 0; bus.cpu_req = 0; bus.cpu_sc = 2'd0;
    bus.ie_set = 0; bus.r0_load = 0; bus.r0_din = 16'h0; bus.mem_q = 8'h00;
    for (int a = 0; a < 65536; a++) ram[a] = 8'h00;
    for (int i = 0; i < 8; i++) ram[16'h0900 + i] = 8'((i + 1) * 8'h11);
    ram[16'hFFFF] = 8'h5A;
    ram[16'h0100] = 8'hA5;

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_sc", 16'(bus.sc), 16'd1);
    chk("rst_tpa", 16'(bus.tpa), 16'd0);
    chk("rst_tpb", 16'(bus.tpb), 16'd0);
    chk("rst_grant", 16'(bus.cpu_grant), 16'd0);
    chk("rst_mem_rd", 16'(bus.mem_rd), 16'd0);
    chk("rst_mem_a", bus.mem_a, 16'h0000);
    chk("rst_dma_data", 16'(bus.dma_data), 16'h00);
    chk("rst_int_ack", 16'(bus.int_ack), 16'd0);
    chk("rst_ie", 16'(bus.ie), 16'd1);
    chk("rst_r0", bus.r0, 16'h0000);

    // Idle: two full cycles of timing with no requests
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk("idle_tpa", 16'(bus.tpa), 16'(mphase == 1));
      chk("idle_tpb", 16'(bus.tpb), 16'(mphase == 6));
      chk("idle_sc", 16'(bus.sc), 16'd1);
      chk("idle_grant", 16'(bus.cpu_grant), 16'd0);
      chk("idle_mem_rd", 16'(bus.mem_rd), 16'd0);
    end

    // Eight-byte DMA burst from 0x0900
    load_r0(16'h0900);
    bus.dma_out_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      wait_phase(0);
      chk("dma_sc", 16'(bus.sc), 16'd2);
      chk("dma_mem_a", bus.mem_a, 16'(16'h0900 + i));
      wait_phase(2);
      chk("dma_mem_rd", 16'(bus.mem_rd), 16'd1);
      wait_phase(4);
      chk("dma_data", 16'(bus.dma_data), 16'((i + 1) * 8'h11));
      if (i == 7) bus.dma_out_req = 1'b0;
    end
    wait_phase(0);
    chk("dma_end_sc", 16'(bus.sc), 16'd1);
    chk("dma_end_r0", bus.r0, 16'h0908);
    chk("dma_hold_data", 16'(bus.dma_data), 16'h88);

    // DMA beats INT; INT follows; second INT blocked until ie_set
    bus.dma_out_req = 1'b1;
    bus.int_req = 1'b1;
    wait_phase(0);
    chk("pri_dma_sc", 16'(bus.sc), 16'd2);
    wait_phase(4);
    bus.dma_out_req = 1'b0;
    wait_phase(0);
    chk("int_sc", 16'(bus.sc), 16'd3);
    chk("int_r0", bus.r0, 16'h0909);
    wait_phase(5);
    chk("int_ack_p5", 16'(bus.int_ack), 16'd0);
    wait_phase(6);
    chk("int_ack_p6", 16'(bus.int_ack), 16'd1);
    chk("int_ie_before", 16'(bus.ie), 16'd1);
    wait_phase(7);
    chk("int_ack_p7", 16'(bus.int_ack), 16'd0);
    chk("int_ie_cleared", 16'(bus.ie), 16'd0);
    wait_phase(0);
    chk("int_blocked_sc", 16'(bus.sc), 16'd1);
    wait_phase(6);
    chk("int_blocked_ack", 16'(bus.int_ack), 16'd0);
    wait_phase(2);
    bus.ie_set = 1'b1;
    @(negedge clk);
    bus.ie_set = 1'b0;
    chk("ie_set", 16'(bus.ie), 16'd1);
    wait_phase(0);
    chk("int2_sc", 16'(bus.sc), 16'd3);
    bus.int_req = 1'b0;
    wait_phase(6);
    chk("int2_ack", 16'(bus.int_ack), 16'd1);
    bus.ie_set = 1'b1;
    @(negedge clk);
    bus.ie_set = 1'b0;
    chk("ack_beats_ie_set", 16'(bus.ie), 16'd0);
    bus.ie_set = 1'b1;
    @(negedge clk);
    bus.ie_set = 1'b0;

    // R0 wrap at 0xFFFF, then load beats increment
    load_r0(16'hFFFF);
    bus.dma_out_req = 1'b1;
    wait_phase(0);
    chk("wrap_sc", 16'(bus.sc), 16'd2);
    chk("wrap_mem_a", bus.mem_a, 16'hFFFF);
    wait_phase(4);
    chk("wrap_data", 16'(bus.dma_data), 16'h5A);
    bus.dma_out_req = 1'b0;
    wait_phase(0);
    chk("wrap_r0", bus.r0, 16'h0000);
    chk("wrap_idle_mem_a", bus.mem_a, 16'h0000);
    bus.dma_out_req = 1'b1;
    wait_phase(0);
    chk("ldpri_sc", 16'(bus.sc), 16'd2);
    bus.dma_out_req = 1'b0;
    wait_phase(7);
    load_r0(16'h1234);
    chk("load_beats_inc", bus.r0, 16'h1234);
    chk("ldpri_after_sc", 16'(bus.sc), 16'd1);

    // CPU fetch cycle; DMA raised mid-cycle waits for the next boundary
    bus.cpu_req = 1'b1;
    bus.cpu_sc = 2'd0;
    wait_phase(0);
    chk("cpu_sc", 16'(bus.sc), 16'd0);
    chk("cpu_grant", 16'(bus.cpu_grant), 16'd1);
    bus.cpu_req = 1'b0;
    wait_phase(3);
    bus.dma_out_req = 1'b1;
    chk("cpu_mid_sc", 16'(bus.sc), 16'd0);
    wait_phase(7);
    chk("cpu_last_grant", 16'(bus.cpu_grant), 16'd1);
    chk("cpu_last_mem_rd", 16'(bus.mem_rd), 16'd0);
    wait_phase(0);
    chk("cpu_then_dma_sc", 16'(bus.sc), 16'd2);
    chk("cpu_then_dma_grant", 16'(bus.cpu_grant), 16'd0);
    bus.dma_out_req = 1'b0;

    // Reset at phase 4 of a DMA cycle
    wait_phase(0);
    load_r0(16'h0100);
    bus.dma_out_req = 1'b1;
    wait_phase(0);
    chk("rdma_mem_a", bus.mem_a, 16'h0100);
    wait_phase(4);
    chk("rdma_data", 16'(bus.dma_data), 16'hA5);
    reset = 1'b1;
    bus.dma_out_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk("rdma_r0", bus.r0, 16'h0000);
    chk("rdma_dma_data", 16'(bus.dma_data), 16'h00);
    chk("rdma_sc", 16'(bus.sc), 16'd1);
    chk("rdma_mem_a0", bus.mem_a, 16'h0000);
    chk("rdma_tpa0", 16'(bus.tpa), 16'd0);
    @(negedge clk);
    chk("rdma_tpa1", 16'(bus.tpa), 16'd1);
    chk("rdma_r0_after", bus.r0, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/cdp1802_dma_responder.md
Name: cdp1802_dma_responder

Overview:
- CPU-side responder to the CDP1861 video chip's DMA and interrupt requests; the other end of the 1861's DMAO/INT/TPA/TPB/SC/DataIn interface.
- Generates 1802-style machine-cycle timing (TPA, TPB, SC state code), arbitrates cycles between the CPU core, DMA-out and interrupt, and fetches display bytes from RAM at R0 for the 1861.
- Sits in the rcastudioii top between the cdp1802 core, the bram and cdp1861.

Parameters:
- CLKS_PER_CYCLE, 8, clock enables per machine cycle; legal range 8..16.
- TPA_PHASE, 1, phase index of the one-clock TPA pulse.
- TPB_PHASE, 6, phase index of the one-clock TPB pulse.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dma_out_req  in  1  DMAO request from cdp1861, active high
- int_req  in  1  INT request from cdp1861, active high
- cpu_req  in  1  core requests a fetch/execute cycle
- cpu_sc  in  2  state code of the core's requested cycle (0 fetch, 1 execute)
- ie_set  in  1  one-clock pulse from the core (RET) setting IE
- r0_load  in  1  core writes R0
- r0_din  in  16  R0 write data
- mem_q  in  8  RAM read data, one-clock latency after mem_rd
- tpa  out  1  timing pulse A
- tpb  out  1  timing pulse B
- sc  out  2  current cycle state code (0 fetch, 1 execute, 2 DMA, 3 interrupt)
- cpu_grant  out  1  high for the whole cycle the core owns
- mem_rd  out  1  RAM read strobe (DMA cycles only)
- mem_a  out  16  RAM address (R0 during DMA)
- dma_data  out  8  byte presented to cdp1861 DataIn
- int_ack  out  1  one-clock pulse at TPB of an interrupt cycle
- ie  out  1  interrupt enable flag
- r0  out  16  current DMA pointer

Behaviour:
- Phase counter 0..CLKS_PER_CYCLE-1, free running, wraps to 0. tpa=1 only at phase TPA_PHASE. tpb=1 only at phase TPB_PHASE.
- Cycle type is decided at the last phase and takes effect at phase 0 of the next cycle. Priority is DMA (dma_out_req=1), then INT (int_req=1 and ie=1), then CPU (cpu_req=1, sc=cpu_sc), then idle execute (sc=1, cpu_grant=0).
- Requests are sampled only at the last phase. A request that rises and falls inside one cycle is lost by design, matching the 1861 contract.
- States: CPU, DMA, INT, IDLE. sc is held constant for the full cycle.
- DMA cycle: mem_a=r0 for phases 0..last. mem_rd=1 at phase 2 only. At phase 3, mem_q is registered into dma_data, which holds until the next DMA cycle loads it. At the last phase, r0<=r0+1 (16-bit, FFFF wraps to 0000).
- Consecutive DMA cycles continue while dma_out_req stays high at each last phase. The 1861 gets 8 bytes per line.
- INT cycle: int_ack pulses at TPB_PHASE and ie<=0 at the same clock. r0 is unchanged; the core vectors itself.
- ie_set sets ie=1. If ie_set and int_ack coincide, ie=0 (ack wins).
- r0_load has priority over a same-clock increment (r0<=r0_din). It is honoured in any phase.
- cpu_grant=1 throughout CPU cycles, 0 otherwise. Outside DMA cycles, mem_a=0 and mem_rd=0.
- Reset values: phase=0, state IDLE, sc=1, tpa=0, tpb=0, cpu_grant=0, mem_rd=0, mem_a=0, dma_data=0, int_ack=0, ie=1, r0=0.
- Reset mid-cycle aborts at once: no r0 increment, no int_ack, and the next cycle begins from phase 0 after release.

Decomposition:
- Shared package cdp18xx_pkg holds the state-code constants SC_FETCH=0, SC_EXEC=1, SC_DMA=2, SC_INT=3 and the cycle-state enum. cdp1861 and the core use the same constants.
- One sub-module, cdp1802_cycle_timer, contains the phase counter, tpa/tpb generation and the last-phase strobe. Arbitration, R0 and ie live in the top of the block.

Test Plan:
- Reset, then idle with no requests -> sc=1, tpa high every 8 clocks at phase 1, tpb at phase 6, cpu_grant=0, mem_rd never asserted.
- r0_load 0x0900, dma_out_req held high for 8 cycles, RAM preloaded 0x11..0x88 -> sc=2 for 8 cycles, dma_data sequence 0x11..0x88 (each valid from phase 4), r0=0x0908 afterwards.
- dma_out_req and int_req both high at the last phase with ie=1 -> DMA cycle first; INT cycle follows once dma_out_req is low; int_ack single pulse; ie=0; a second int_req is ignored until ie_set.
- r0=0xFFFF, one DMA cycle -> mem_a=0xFFFF, r0 becomes 0x0000. Then r0_load 0x1234 at the last phase of a DMA cycle -> r0=0x1234 (load beats increment).
- cpu_req=1 with cpu_sc=0 and no video requests -> sc=0, cpu_grant=1 for the full cycle. dma_out_req raised mid-cycle -> the CPU cycle completes, and the next cycle is DMA.
- Reset asserted at phase 4 of a DMA cycle with r0=0x0100 -> r0=0, dma_data=0, no increment, and after release the phase restarts at 0 with sc=1.
